dog_extrema_detect: RTL and testbench
=====================================

# dog_extrema_detect

Keypoint-detection stage that runs after the Gaussian-blur stage has filled the four blurred-image memories. It reads the four blurred rows in lockstep and forms three Difference-of-Gaussian (DoG) rows in parallel. It keeps a 3-row DoG window and flags 26-neighbour extrema of the middle DoG layer. It then serialises the flagged pixels as (row, col) keypoints over a valid/ready stream. The top-level FSM drives `start` when it enters the keypoint-detection state and waits for `done`.

## Interface
Parameters:
- IMG_W, 640: pixels per row
- IMG_H, 480: rows per image
- PIX_W, 8: bits per blurred pixel (unsigned)
- THRESH, 3: contrast threshold; a keypoint needs |DoG| > THRESH
- ROW_AW, 9: row-address / kp_row width
- COL_AW, 10: kp_col width

Ports:
- Reset rst_n, synchronous, active-low; clock clk.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- blur_addr  out  ROW_AW  row address, shared by all four blurred memories
- blur_dout_0..blur_dout_3  in  IMG_W*PIX_W each  row data; pixel c occupies bits [c*PIX_W +: PIX_W]; index 0 is the least-blurred image
- kp_valid  out  1  keypoint present
- kp_ready  in  1  consumer accepts keypoint
- kp_row  out  ROW_AW  keypoint row
- kp_col  out  COL_AW  keypoint column
- kp_count  out  16  keypoints emitted since last start; saturates at 16'hFFFF
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of frame

## Operation
- DoG arithmetic:
  - dog_k[c] = blur_{k+1}[c] - blur_k[c] for k = 0..2.
  - Signed, PIX_W+1 bits, no saturation.
- Window registers win0/win1/win2 (oldest to newest). Each holds all three DoG layers for one row.
  - A load shifts win0<=win1, win1<=win2, win2<=new.
- Extremum flag for column c of centre row win1, layer dog_1:
  - Either strictly greater than all 26 neighbours, or strictly less than all 26.
  - The 26 neighbours are the 8 in-layer dog_1 pixels plus 9 dog_0 and 9 dog_2 pixels at rows win0..win2, cols c-1..c+1.
  - Also requires |dog_1| > THRESH.
  - Flags are combinational from the window and stable during SCAN.
- Borders are never reported:
  - Rows 0 and IMG_H-1 are never a centre row.
  - Columns 0 and IMG_W-1 are never scanned.
- FSM states:
  - IDLE: busy=0. On start: row counter r=0, loaded=0, kp_count=0, go FETCH.
  - FETCH: blur_addr=r. Go LOAD.
  - LOAD: capture the blur_dout rows, compute DoG, shift the window, increment loaded (saturates at 3).
    - If loaded (post-increment) >= 3: col=1, go SCAN.
    - Else if r==IMG_H-1: go DONE.
    - Else: r++, go FETCH.
  - SCAN: centre row = r-1. Each cycle:
    - If flag[col]=0: col++.
    - If flag[col]=1: present kp_valid with kp_row=r-1, kp_col=col. Hold until kp_ready, then kp_count++ and col++.
    - After col IMG_W-2 is finished: go DONE if r==IMG_H-1, else r++ and go FETCH.
  - DONE: done=1 for one cycle, go IDLE.
- start outside IDLE is ignored.

## Timing
- Reset values: blur_addr=0, kp_valid=0, kp_row=0, kp_col=0, kp_count=0, busy=0, done=0; FSM in IDLE.
- Memory read latency is 1 cycle: the address driven in FETCH is matched by data in LOAD.
- kp_valid/kp_row/kp_col are registered. Once kp_valid rises, it and its data stay stable until the cycle after kp_ready=1 is sampled.
- Zero-keypoint / always-ready cycle count, from the start-sample edge to the done cycle inclusive: 2*IMG_H + (IMG_H-2)*(IMG_W-2) + 1. Flagged pixels add no cycles when kp_ready stays high.
  - For IMG_W=8, IMG_H=6: 12 + 24 + 1 = 37.
- Each cycle with kp_valid=1 and kp_ready=0 adds exactly one cycle.
- Reset mid-frame returns to IDLE and clears all outputs; no done pulse is issued.
- kp_count saturates and never wraps.

## Test plan
- IMG_W=8, IMG_H=6, all four images constant 10 -> no kp_valid; done pulse 37 cycles after start; kp_count=0.
- blur_2 = 50 at (3,4), all other pixels 10 -> exactly one keypoint (kp_row=3, kp_col=4); kp_count=1.
- Same as above with the centre DoG set to 3 (blur_2=13) -> no keypoint; with 4 (blur_2=14) -> one keypoint. Repeat with blur_2=6 (DoG -4) -> one minimum keypoint.
- Peak placed at (0,4), (3,0) and (3,7) -> no keypoints.
- Two peaks at (2,2) and (2,5), kp_ready held low 5 cycles on the first -> kp_valid and data stable for 6 cycles; keypoints come out in order (2,2) then (2,5); done 5 cycles later than the unstalled run; kp_count=2.
- rst_n low for 1 cycle mid-SCAN -> all outputs 0, no done; a new start produces the full, correct keypoint list.

Source files
------------

// File: rtl/dog_extrema_detect.sv
// Difference-of-Gaussian extremum detector: builds a 3-row DoG window from four
// blurred-image rows and streams 26-neighbour extrema of the middle layer as (row, col).
module dog_extrema_detect #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int PIX_W  = 8,
  parameter int THRESH = 3,
  parameter int ROW_AW = 9,
  parameter int COL_AW = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [ROW_AW-1:0]        blur_addr,
  input  logic [IMG_W*PIX_W-1:0]   blur_dout_0,
  input  logic [IMG_W*PIX_W-1:0]   blur_dout_1,
  input  logic [IMG_W*PIX_W-1:0]   blur_dout_2,
  input  logic [IMG_W*PIX_W-1:0]   blur_dout_3,
  output logic                     kp_valid,
  input  logic                     kp_ready,
  output logic [ROW_AW-1:0]        kp_row,
  output logic [COL_AW-1:0]        kp_col,
  output logic [15:0]              kp_count,
  output logic                     busy,
  output logic                     done
);

  localparam int DW = PIX_W + 1;
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(IMG_H - 1);
  localparam logic [COL_AW-1:0] LAST_COL = COL_AW'(IMG_W - 2);
  localparam logic signed [DW-1:0] THR_P = DW'(THRESH);
  localparam logic signed [DW-1:0] THR_N = -THR_P;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SCAN, S_DONE} state_t;

  state_t              r_state;
  logic [ROW_AW-1:0]   r_row;
  logic [COL_AW-1:0]   r_col;
  logic [1:0]          r_loaded;
  logic                r_kp_valid;
  logic [ROW_AW-1:0]   r_kp_row;
  logic [COL_AW-1:0]   r_kp_col;
  logic [15:0]         r_kp_count;
  logic signed [DW-1:0] r_win [3][3][IMG_W];  // [row slot][DoG layer][col]

  logic [PIX_W-1:0]     w_blur [4][IMG_W];
  logic signed [DW-1:0] w_dog  [3][IMG_W];
  logic signed [DW-1:0] w_eval [3][3][IMG_W];
  logic [IMG_W-1:0]     w_flag;
  logic                 w_is_load;
  logic [COL_AW-1:0]    w_col_next;
  logic                 w_next_flag;
  logic [1:0]           w_loaded_inc;

  assign w_is_load = (r_state == S_LOAD);

  genvar gi, gl;
  generate
    for (gi = 0; gi < IMG_W; gi++) begin : g_col
      assign w_blur[0][gi] = blur_dout_0[gi*PIX_W +: PIX_W];
      assign w_blur[1][gi] = blur_dout_1[gi*PIX_W +: PIX_W];
      assign w_blur[2][gi] = blur_dout_2[gi*PIX_W +: PIX_W];
      assign w_blur[3][gi] = blur_dout_3[gi*PIX_W +: PIX_W];
      for (gl = 0; gl < 3; gl++) begin : g_layer
        assign w_dog[gl][gi] = $signed({1'b0, w_blur[gl+1][gi]}) - $signed({1'b0, w_blur[gl][gi]});
        // During LOAD the flags are evaluated on the window as it will be after the shift,
        // so the first column's keypoint can be registered on the way into SCAN.
        assign w_eval[0][gl][gi] = w_is_load ? r_win[1][gl][gi] : r_win[0][gl][gi];
        assign w_eval[1][gl][gi] = w_is_load ? r_win[2][gl][gi] : r_win[1][gl][gi];
        assign w_eval[2][gl][gi] = w_is_load ? w_dog[gl][gi]    : r_win[2][gl][gi];
      end
    end

    assign w_flag[0]       = 1'b0;
    assign w_flag[IMG_W-1] = 1'b0;
    for (gi = 1; gi < IMG_W - 1; gi++) begin : g_ext
      logic w_gt, w_lt;
      always_comb begin
        w_gt = 1'b1;
        w_lt = 1'b1;
        for (int s = 0; s < 3; s++) begin
          for (int l = 0; l < 3; l++) begin
            for (int d = -1; d <= 1; d++) begin
              if (!(s == 1 && l == 1 && d == 0)) begin
                if (w_eval[1][1][gi] <= w_eval[s][l][gi+d]) w_gt = 1'b0;
                if (w_eval[1][1][gi] >= w_eval[s][l][gi+d]) w_lt = 1'b0;
              end
            end
          end
        end
      end
      assign w_flag[gi] = (w_gt | w_lt) &
                          ((w_eval[1][1][gi] > THR_P) | (w_eval[1][1][gi] < THR_N));
    end
  endgenerate

  assign w_col_next   = w_is_load ? COL_AW'(1) : r_col + 1'b1;
  assign w_loaded_inc = (r_loaded == 2'd3) ? 2'd3 : r_loaded + 2'd1;

  always_comb begin
    w_next_flag = 1'b0;
    for (int i = 0; i < IMG_W; i++) begin
      if (w_col_next == COL_AW'(i)) w_next_flag = w_flag[i];
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      for (int l = 0; l < 3; l++) begin
        for (int c = 0; c < IMG_W; c++) begin
          r_win[0][l][c] <= r_win[1][l][c];
          r_win[1][l][c] <= r_win[2][l][c];
          r_win[2][l][c] <= w_dog[l][c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_loaded   <= '0;
      r_kp_valid <= 1'b0;
      r_kp_row   <= '0;
      r_kp_col   <= '0;
      r_kp_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row      <= '0;
            r_loaded   <= '0;
            r_kp_count <= '0;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_loaded <= w_loaded_inc;
          if (w_loaded_inc == 2'd3) begin
            r_col      <= w_col_next;
            r_kp_valid <= w_next_flag;
            if (w_next_flag) begin
              r_kp_row <= r_row - 1'b1;
              r_kp_col <= w_col_next;
            end
            r_state <= S_SCAN;
          end else if (r_row == LAST_ROW) begin
            r_state <= S_DONE;
          end else begin
            r_row   <= r_row + 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_SCAN: begin
          if (!r_kp_valid || kp_ready) begin
            if (r_kp_valid && r_kp_count != 16'hFFFF) r_kp_count <= r_kp_count + 16'd1;
            if (r_col == LAST_COL) begin
              r_kp_valid <= 1'b0;
              if (r_row == LAST_ROW) begin
                r_state <= S_DONE;
              end else begin
                r_row   <= r_row + 1'b1;
                r_state <= S_FETCH;
              end
            end else begin
              r_col      <= w_col_next;
              r_kp_valid <= w_next_flag;
              if (w_next_flag) begin
                r_kp_row <= r_row - 1'b1;
                r_kp_col <= w_col_next;
              end
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign blur_addr = r_row;
  assign kp_valid  = r_kp_valid;
  assign kp_row    = r_kp_row;
  assign kp_col    = r_kp_col;
  assign kp_count  = r_kp_count;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_dog_extrema_detect.sv
// Scoreboard bench for dog_extrema_detect on an 8x6 image: directed peaks, borders,
// threshold edges, back-pressure and mid-frame reset.
module tb_dog_extrema_detect;
  localparam int W = 8;
  localparam int H = 6;

  typedef struct {
    int row;
    int col;
  } kp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [8:0]    blur_addr;
  logic [W*8-1:0] blur_dout_0, blur_dout_1, blur_dout_2, blur_dout_3;
  logic          kp_valid;
  logic          kp_ready = 1'b1;
  logic [8:0]    kp_row;
  logic [9:0]    kp_col;
  logic [15:0]   kp_count;
  logic          busy, done;

  logic [7:0] img [4][H][W];
  kp_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         stall_req = 0;
  int         stall_gen = 0;
  int         exp_hold = 0;

  dog_extrema_detect #(
    .IMG_W(W), .IMG_H(H), .PIX_W(8), .THRESH(3), .ROW_AW(9), .COL_AW(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .blur_addr(blur_addr),
    .blur_dout_0(blur_dout_0), .blur_dout_1(blur_dout_1),
    .blur_dout_2(blur_dout_2), .blur_dout_3(blur_dout_3),
    .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_row(kp_row), .kp_col(kp_col),
    .kp_count(kp_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W*8-1:0] row_bits(input int k, input int a);
    logic [W*8-1:0] v;
    v = '0;
    if (a < H) for (int c = 0; c < W; c++) v[c*8 +: 8] = img[k][a][c];
    return v;
  endfunction

  // Blurred memories with one cycle of read latency.
  always @(posedge clk) begin
    blur_dout_0 <= row_bits(0, int'(blur_addr));
    blur_dout_1 <= row_bits(1, int'(blur_addr));
    blur_dout_2 <= row_bits(2, int'(blur_addr));
    blur_dout_3 <= row_bits(3, int'(blur_addr));
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Consumer and monitor: pops the scoreboard on each accepted keypoint.
  int  stall_cnt = 0;
  int  seen_gen = 0;
  bit  holding = 1'b0;
  int  hold_n = 0;
  int  h_row = 0, h_col = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      holding   = 1'b0;
      stall_cnt = 0;
      kp_ready  = 1'b1;
    end else if (kp_valid) begin
      if (stall_gen != seen_gen && !holding) begin
        seen_gen  = stall_gen;
        stall_cnt = stall_req;
        if (stall_cnt > 0) begin
          holding = 1'b1;
          hold_n  = 0;
          h_row   = int'(kp_row);
          h_col   = int'(kp_col);
        end
      end
      if (holding) begin
        hold_n++;
        check("kp_hold_row", int'(kp_row), h_row);
        check("kp_hold_col", int'(kp_col), h_col);
      end
      if (stall_cnt > 0) begin
        kp_ready = 1'b0;
        stall_cnt--;
      end else begin
        kp_ready = 1'b1;
        if (holding) begin
          check("kp_hold_len", hold_n, exp_hold);
          holding = 1'b0;
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL kp_unexpected: got (%0d,%0d), expected none", kp_row, kp_col);
        end else begin
          kp_t e;
          e = exp_q.pop_front();
          $display("keypoint row=%0d col=%0d (expected %0d,%0d)", kp_row, kp_col, e.row, e.col);
          check("kp_row", int'(kp_row), e.row);
          check("kp_col", int'(kp_col), e.col);
        end
      end
    end else begin
      kp_ready = 1'b1;
    end
  end

  task automatic set_all(input int v);
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) img[k][r][c] = 8'(v);
  endtask

  task automatic expect_kp(input int r, input int c);
    kp_t e;
    e.row = r;
    e.col = c;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_frame(input string name, input int exp_cycles, input int exp_count);
    int cyc;
    bit got;
    pulse_start();
    cyc = 0;
    got = 1'b0;
    while (cyc < 300 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({name, "_busy"}, int'(busy), 1);
      if (done) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done, expected done within 300 cycles", name);
    end else begin
      check({name, "_cycles"}, cyc, exp_cycles);
      check({name, "_count"}, int'(kp_count), exp_count);
      check({name, "_pending"}, exp_q.size(), 0);
      $display("frame %s: done after %0d cycles, kp_count=%0d", name, cyc, kp_count);
      @(negedge clk);
      check({name, "_done_pulse"}, int'(done), 0);
      check({name, "_idle"}, int'(busy), 0);
    end
    exp_q.delete();
  endtask

  initial begin
    set_all(10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", int'(blur_addr), 0);
    check("rst_valid", int'(kp_valid), 0);
    check("rst_row", int'(kp_row), 0);
    check("rst_col", int'(kp_col), 0);
    check("rst_count", int'(kp_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;

    set_all(10);
    run_frame("flat", 37, 0);

    set_all(10); img[2][3][4] = 8'd50; expect_kp(3, 4);
    run_frame("peak", 37, 1);

    set_all(10); img[2][3][4] = 8'd13;
    run_frame("dog3", 37, 0);

    set_all(10); img[2][3][4] = 8'd14; expect_kp(3, 4);
    run_frame("dog4", 37, 1);

    set_all(10); img[2][3][4] = 8'd6; expect_kp(3, 4);
    run_frame("min", 37, 1);

    set_all(10); img[2][0][4] = 8'd50; img[2][3][0] = 8'd50; img[2][3][7] = 8'd50;
    run_frame("border", 37, 0);

    set_all(10); img[2][2][2] = 8'd50; img[2][2][5] = 8'd50;
    expect_kp(2, 2); expect_kp(2, 5);
    stall_req = 5; exp_hold = 6; stall_gen++;
    run_frame("stall", 42, 2);
    check("stall_consumed", int'(holding), 0);
    stall_req = 0;

    // Abort a frame in SCAN (cycle 20), then rerun it from scratch.
    set_all(10); img[2][3][4] = 8'd50;
    pulse_start();
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_addr", int'(blur_addr), 0);
    check("mid_rst_valid", int'(kp_valid), 0);
    check("mid_rst_row", int'(kp_row), 0);
    check("mid_rst_col", int'(kp_col), 0);
    check("mid_rst_count", int'(kp_count), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    rst_n = 1'b1;
    begin
      int seen_done;
      seen_done = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) seen_done++;
      end
      check("mid_rst_quiet", seen_done, 0);
    end
    expect_kp(3, 4);
    run_frame("restart", 37, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
